// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared types and constants for the GCD engine: controller
//                state encoding and the algorithm-select values.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package gcd_pkg;

  // Controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_e;

  // Algorithm select values for the ALGO parameter
  localparam int GCD_SUB = 0;  // repeated subtraction
  localparam int GCD_BIN = 1;  // Stein's binary algorithm

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/gcd_step.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_step
//  Description : Combinational single-iteration next-value logic for the GCD
//                engine. Produces the next A/B/k values and an equality flag
//                for the current operand pair.
//  Ports       : a_i, b_i  current operands          (WIDTH)
//                k_i       common power-of-two count  (KW)
//                a_o, b_o  next operands              (WIDTH)
//                k_o       next power-of-two count    (KW)
//                eq_o      A == B, iteration finished
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ALGO  = GCD_SUB,
  parameter int KW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [KW-1:0]    k_o,
  output logic             eq_o
);

  logic a_gt_b;

  assign eq_o   = (a_i == b_i);
  assign a_gt_b = (a_i > b_i);

  generate
    if (ALGO == GCD_BIN) begin : g_bin
      // Priority: both even, A even, B even, both odd.
      always_comb begin
        a_o = a_i;
        b_o = b_i;
        k_o = k_i;
        if (!a_i[0] && !b_i[0]) begin
          a_o = a_i >> 1;
          b_o = b_i >> 1;
          k_o = k_i + KW'(1);
        end else if (!a_i[0]) begin
          a_o = a_i >> 1;
        end else if (!b_i[0]) begin
          b_o = b_i >> 1;
        end else if (a_gt_b) begin
          a_o = a_i - b_i;
        end else begin
          b_o = b_i - a_i;
        end
      end
    end else begin : g_sub
      // k is unused by subtraction; pass it through unchanged.
      always_comb begin
        a_o = a_i;
        b_o = b_i;
        k_o = k_i;
        if (a_gt_b) begin
          a_o = a_i - b_i;
        end else begin
          b_o = b_i - a_i;
        end
      end
    end
  endgenerate

endmodule : gcd_step
`default_nettype wire

// File: rtl/gcd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_engine
//  Description : Greatest-common-divisor engine, one iteration per clock,
//                subtractive or Stein's binary algorithm chosen by ALGO.
//                Operands arrive over a valid/ready handshake; the result and
//                the number of CALC cycles leave over a second one.
//  Ports       : clk, rst_n             clock, async active-low reset
//                in_valid/in_ready      operand handshake
//                a_in, b_in             operands (WIDTH)
//                out_valid/out_ready    result handshake
//                gcd_out                result (WIDTH)
//                iter_count             CALC cycles used (CNT_W)
//                busy                   high while iterating
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ALGO  = GCD_SUB,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy
);

  // k counts common factors of two and never exceeds WIDTH-1.
  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic [KW-1:0]    step_k;
  logic             step_eq;

  gcd_step #(
    .WIDTH (WIDTH),
    .ALGO  (ALGO),
    .KW    (KW)
  ) u_step (
    .a_i  (a_q),
    .b_i  (b_q),
    .k_i  (k_q),
    .a_o  (step_a),
    .b_o  (step_b),
    .k_o  (step_k),
    .eq_o (step_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = a_in;
          b_d   = b_in;
          k_d   = '0;
          cnt_d = '0;
          // A zero operand needs no iteration: gcd(x,0)=x, gcd(0,0)=0.
          if ((a_in == '0) || (b_in == '0)) begin
            res_d   = a_in | b_in;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (step_eq) begin
          // Restore the common power of two removed by the binary steps.
          res_d   = (ALGO == GCD_BIN) ? (a_q << k_q) : a_q;
          state_d = ST_DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
          k_d = step_k;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_CALC);
  assign gcd_out    = res_q;
  assign iter_count = cnt_q;

endmodule : gcd_engine
`default_nettype wire

// File: tb/tb_gcd_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_engine
//  Description : Self-checking bench for gcd_engine. Three instances share
//                clock and reset: subtractive 16-bit, binary 16-bit and
//                subtractive 8-bit. Expected results go into a scoreboard
//                queue when operands are driven and are compared when the
//                instance raises out_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gcd_engine;

  localparam int TMO = 5000;

  typedef struct {
    int          d;      // instance: 0 sub16, 1 bin16, 2 sub8
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;      // expected gcd
    int          n;      // expected iteration count
    bit          exact;  // 0: only bound-check the iteration count
  } vec_t;

  logic clk;
  logic rst_n;
  logic        in_valid_s [3];
  logic        in_ready_s [3];
  logic [15:0] a_s        [3];
  logic [15:0] b_s        [3];
  logic        out_valid_s[3];
  logic        out_ready_s[3];
  logic [15:0] gcd_s      [3];
  logic [16:0] iter_s     [3];
  logic        busy_s     [3];
  logic [7:0]  gcd8;
  logic [8:0]  iter8;

  int n_vec;
  int n_miss;
  vec_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16), .ALGO(0)) u_sub (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a_in(a_s[0]), .b_in(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .gcd_out(gcd_s[0]), .iter_count(iter_s[0]), .busy(busy_s[0])
  );

  gcd_engine #(.WIDTH(16), .ALGO(1)) u_bin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a_in(a_s[1]), .b_in(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .gcd_out(gcd_s[1]), .iter_count(iter_s[1]), .busy(busy_s[1])
  );

  gcd_engine #(.WIDTH(8), .ALGO(0)) u_sub8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a_in(a_s[2][7:0]), .b_in(b_s[2][7:0]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .gcd_out(gcd8), .iter_count(iter8), .busy(busy_s[2])
  );

  assign gcd_s[2]  = {8'h00, gcd8};
  assign iter_s[2] = {8'h00, iter8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Euclid by division. For subtraction the CALC cycle count equals the sum
  // of the Euclid quotients (the last subtraction becomes the A==B cycle).
  function automatic void model_sub(input int a, input int b, output int g, output int n);
    int x, y, t;
    x = a; y = b; n = 0;
    while (y != 0) begin
      n += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
  endfunction

  task automatic run_op(input vec_t v);
    vec_t e;
    int   edges;
    bit   done;
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready_s[v.d]}, 32'd1);
    in_valid_s[v.d] = 1'b1;
    a_s[v.d] = v.a;
    b_s[v.d] = v.b;
    sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid_s[v.d] = 1'b0;
    a_s[v.d] = 16'($urandom);
    b_s[v.d] = 16'($urandom);
    edges = 0;
    done  = 1'b0;
    while (!done && edges < TMO) begin
      @(negedge clk);
      if (out_valid_s[v.d]) done = 1'b1;
      else begin
        chk("busy_calc", {31'b0, busy_s[v.d]}, 32'd1);
        @(posedge clk);
        edges++;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: gcd(%0d,%0d) on dut %0d got no out_valid expected within %0d cycles",
               e.a, e.b, e.d, TMO);
    end else begin
      chk("gcd_out", {16'b0, gcd_s[e.d]}, {16'b0, e.g});
      chk("busy_done", {31'b0, busy_s[e.d]}, 32'd0);
      chk("in_ready_done", {31'b0, in_ready_s[e.d]}, 32'd0);
      if (e.exact) begin
        chk("iter_count", {15'b0, iter_s[e.d]}, e.n);
        chk("latency", edges, e.n);
      end else begin
        chk("iter_bound", {31'b0, (iter_s[e.d] <= 17'd33)}, 32'd1);
      end
    end
    out_ready_s[v.d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[v.d] = 1'b0;
    @(negedge clk);
    chk("out_valid_clr", {31'b0, out_valid_s[v.d]}, 32'd0);
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_in_ready",  {31'b0, in_ready_s[d]},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid_s[d]}, 32'd0);
    chk("rst_busy",      {31'b0, busy_s[d]},      32'd0);
    chk("rst_gcd",       {16'b0, gcd_s[d]},       32'd0);
    chk("rst_iter",      {15'b0, iter_s[d]},      32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   g, n;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      a_s[i] = '0;
      b_s[i] = '0;
    end

    tbl.push_back('{0, 16'd48,  16'd18, 16'd6,  5,   1'b1});
    tbl.push_back('{0, 16'd0,   16'd25, 16'd25, 0,   1'b1});
    tbl.push_back('{0, 16'd0,   16'd0,  16'd0,  0,   1'b1});
    tbl.push_back('{0, 16'd17,  16'd17, 16'd17, 1,   1'b1});
    tbl.push_back('{0, 16'd25,  16'd0,  16'd25, 0,   1'b1});
    tbl.push_back('{0, 16'd18,  16'd48, 16'd6,  5,   1'b1});
    tbl.push_back('{1, 16'd48,  16'd18, 16'd6,  7,   1'b1});
    tbl.push_back('{1, 16'd0,   16'd25, 16'd25, 0,   1'b1});
    tbl.push_back('{1, 16'd0,   16'd0,  16'd0,  0,   1'b1});
    tbl.push_back('{1, 16'd17,  16'd17, 16'd17, 1,   1'b1});
    tbl.push_back('{1, 16'd12,  16'd8,  16'd4,  6,   1'b1});
    tbl.push_back('{1, 16'd100, 16'd75, 16'd25, 5,   1'b1});
    tbl.push_back('{2, 16'd255, 16'd1,  16'd1,  255, 1'b1});

    #12;
    for (int d = 0; d < 3; d++) chk_reset_vals(d);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Random operands: exact model for subtraction, gcd plus bound for binary.
    for (int i = 0; i < 24; i++) begin
      v.d = i % 2;
      v.a = 16'($urandom_range(1, 600));
      v.b = 16'($urandom_range(1, 600));
      model_sub(int'(v.a), int'(v.b), g, n);
      v.g = 16'(g);
      v.n = n;
      v.exact = (v.d == 0);
      run_op(v);
    end

    // DONE held for 10 cycles with out_ready low; a second in_valid is ignored.
    @(negedge clk);
    in_valid_s[0] = 1'b1; a_s[0] = 16'd30; b_s[0] = 16'd12;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, out_valid_s[0]}, 32'd1);
      chk("hold_gcd",       {16'b0, gcd_s[0]},       32'd6);
      chk("hold_iter",      {15'b0, iter_s[0]},      32'd4);
      chk("hold_in_ready",  {31'b0, in_ready_s[0]},  32'd0);
      in_valid_s[0] = (c >= 3 && c <= 5);
      a_s[0] = 16'd99; b_s[0] = 16'd33;
    end
    in_valid_s[0] = 1'b0;
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_ghost_valid", {31'b0, out_valid_s[0]}, 32'd0);
      chk("hold_no_ghost_busy",  {31'b0, busy_s[0]},      32'd0);
    end

    // Asynchronous reset in the middle of CALC of (1000,3).
    @(negedge clk);
    in_valid_s[0] = 1'b1; a_s[0] = 16'd1000; b_s[0] = 16'd3;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'b0, busy_s[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {31'b0, out_valid_s[0]}, 32'd0);
    end
    run_op('{0, 16'd12, 16'd8, 16'd4, 3, 1'b1});
    run_op('{1, 16'd12, 16'd8, 16'd4, 6, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_gcd_engine
`default_nettype wire
